// File: rtl/smc_pkg.sv
// Shared definitions for the SMC nominal-model sequencer.
// Holds the step state encoding, shared adder/multiplier select codes,
// saturation limits and a 64-bit to 32-bit saturation helper.
package smc_pkg;

  // One state per datapath step; every state lasts exactly one clock.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_VMUL = 3'd2,
    ST_VADD = 3'd3,
    ST_PMUL = 3'd4,
    ST_PADD = 3'd5,
    ST_CAL  = 3'd6,
    ST_DONE = 3'd7
  } smc_state_e;

  // Adder/subtractor operation codes.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Multiplier x-operand select.
  localparam logic MUL_X_ACC = 1'b0;
  localparam logic MUL_X_VEL = 1'b1;

  // Adder operand-pair select.
  typedef enum logic [1:0] {
    ADD_SEL_VEL = 2'd0,
    ADD_SEL_POS = 2'd1,
    ADD_SEL_ERR = 2'd2
  } add_sel_e;

  localparam logic signed [31:0] SAT32_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT32_MIN = 32'sh8000_0000;
  localparam logic signed [47:0] SAT48_MAX = 48'sh7FFF_FFFF_FFFF;
  localparam logic signed [47:0] SAT48_MIN = 48'sh8000_0000_0000;

  localparam logic signed [63:0] SAT32_MAX_W = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT32_MIN_W = 64'shFFFF_FFFF_8000_0000;

  // Clamp a wide signed value into the signed 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    logic signed [31:0] r;
    if (v > SAT32_MAX_W) begin
      r = SAT32_MAX;
    end else if (v < SAT32_MIN_W) begin
      r = SAT32_MIN;
    end else begin
      r = v[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_adder.sv
// Saturating signed adder/subtractor.
// Ports: a, b - signed N-bit operands; op - 0 add, 1 subtract (a - b);
//        s - result clamped to signed N bits.
module fixed_adder #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic                op,
  output logic signed [N-1:0] s
);

  logic [N:0] ext_s;

  // One guard bit is enough to detect overflow of a single add/sub.
  always_comb begin
    if (op) begin
      ext_s = {a[N-1], a} - {b[N-1], b};
    end else begin
      ext_s = {a[N-1], a} + {b[N-1], b};
    end
  end

  // Guard and sign disagree only on overflow; the guard gives the true sign.
  always_comb begin
    if (ext_s[N] != ext_s[N-1]) begin
      s = ext_s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      s = ext_s[N-1:0];
    end
  end

endmodule

// File: rtl/fixed_multiplier.sv
// Saturating signed multiplier.
// Ports: a, b - signed N-bit operands; p - product clamped to signed N bits.
module fixed_multiplier #(
  parameter int N = 48
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] p
);

  logic signed [2*N-1:0] full_s;
  logic                  pos_ovf_s;
  logic                  neg_ovf_s;

  assign full_s = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});

  // The product fits only if all bits from N-1 upward equal the sign bit.
  assign pos_ovf_s = ~full_s[2*N-1] & (|full_s[2*N-2:N-1]);
  assign neg_ovf_s =  full_s[2*N-1] & ~(&full_s[2*N-2:N-1]);

  // Clamp the full-width product into N bits.
  always_comb begin
    if (pos_ovf_s) begin
      p = {1'b0, {(N-1){1'b1}}};
    end else if (neg_ovf_s) begin
      p = {1'b1, {(N-1){1'b0}}};
    end else begin
      p = full_s[N-1:0];
    end
  end

endmodule

// File: rtl/smc_seq_fsm.sv
// Step controller for the nominal-model sequencer.
// Ports: clk, rst_n; start - sample strobe; state_o - current step;
//        latch_en - capture u/theta this cycle; mul_sel/add_sel/add_op -
//        shared-unit operand selects; busy, done, overrun - registered status.
module smc_seq_fsm import smc_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output smc_state_e state_o,
  output logic       latch_en,
  output logic       mul_sel,
  output add_sel_e   add_sel,
  output logic       add_op,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  smc_state_e state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       overrun_q, overrun_d;

  // Next state, status and shared-unit selects.
  always_comb begin
    state_d   = state_q;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    latch_en  = 1'b0;
    mul_sel   = MUL_X_ACC;
    add_sel   = ADD_SEL_VEL;
    add_op    = OP_ADD;
    // Any start outside IDLE is dropped and flagged.
    overrun_d = start & (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        // busy stays up through the done-pulse cycle, then follows start.
        busy_d = start;
        if (start) begin
          state_d  = ST_LOAD;
          latch_en = 1'b1;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LOAD: state_d = ST_VMUL;
      ST_VMUL: begin
        mul_sel = MUL_X_ACC;
        state_d = ST_VADD;
      end
      ST_VADD: begin
        add_sel = ADD_SEL_VEL;
        state_d = ST_PMUL;
      end
      ST_PMUL: begin
        mul_sel = MUL_X_VEL;
        state_d = ST_PADD;
      end
      ST_PADD: begin
        add_sel = ADD_SEL_POS;
        state_d = ST_CAL;
      end
      ST_CAL: begin
        add_sel = ADD_SEL_ERR;
        add_op  = OP_SUB;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign state_o = state_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/smc_nominal_sequencer.sv
// SMC nominal-model integrator: per start strobe computes
//   velocity += sat(u<<ACC_SHIFT)*TS, position += (velocity*TS)>>>POS_SHIFT,
// then optionally re-synchronises position to the measured angle.
// Ports: clk, rst_n; start - sample strobe; resync_en - allow reload;
//        theta - measured angle; u - control effort; busy/done/overrun/resync -
//        status pulses; thetan/dthetan - nominal position/velocity (En14);
//        dthetan_d2 - velocity two steps back; err_abs - |position error|.
module smc_nominal_sequencer import smc_pkg::*; #(
  parameter int          TS        = 2,
  parameter int          ACC_SHIFT = 2,
  parameter int          POS_SHIFT = 16,
  parameter int          POS_FRAC  = 14,
  parameter logic [31:0] RESYNC_TH = 32'd10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        resync_en,
  input  logic [31:0] theta,
  input  logic [31:0] u,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        resync,
  output logic [31:0] thetan,
  output logic [31:0] dthetan,
  output logic [31:0] dthetan_d2,
  output logic [31:0] err_abs
);

  localparam logic signed [47:0] TS_W = 48'(TS);

  smc_state_e state_s;
  logic       latch_en_s, mul_sel_s, add_op_s;
  add_sel_e   add_sel_s;

  logic signed [31:0] u_l_q, u_l_d, theta_l_q, theta_l_d, acc_q, acc_d;
  logic signed [47:0] prod_q, prod_d;
  logic signed [31:0] dthetan_nxt_q, dthetan_nxt_d, thetan_nxt_q, thetan_nxt_d;
  logic signed [31:0] err_q, err_d, dthetan_d1_q, dthetan_d1_d;
  logic               resync_flag_q, resync_flag_d, resync_q, resync_d;
  logic signed [31:0] thetan_q, thetan_d, dthetan_q, dthetan_d;
  logic signed [31:0] dthetan_d2_q, dthetan_d2_d, err_abs_q, err_abs_d;

  logic signed [47:0] mul_x_s, mul_p_s;
  logic signed [31:0] add_a_s, add_b_s, sum_s, pinc_s, abs_s;
  logic signed [63:0] u_wide_s, theta_wide_s;

  smc_seq_fsm u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .state_o  (state_s),
    .latch_en (latch_en_s),
    .mul_sel  (mul_sel_s),
    .add_sel  (add_sel_s),
    .add_op   (add_op_s),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  assign mul_x_s = (mul_sel_s == MUL_X_VEL) ? {{16{dthetan_nxt_q[31]}}, dthetan_nxt_q}
                                            : {{16{acc_q[31]}}, acc_q};

  fixed_multiplier #(.N(48)) u_mul (.a(mul_x_s), .b(TS_W), .p(mul_p_s));

  // Position increment: truncate the shifted 48-bit product to 32 bits.
  assign pinc_s = 32'(prod_q >>> POS_SHIFT);

  // Shared adder operand mux.
  always_comb begin
    add_a_s = 32'sd0;
    add_b_s = 32'sd0;
    case (add_sel_s)
      ADD_SEL_VEL: begin
        add_a_s = dthetan_q;
        add_b_s = prod_q[31:0];
      end
      ADD_SEL_POS: begin
        add_a_s = thetan_q;
        add_b_s = pinc_s;
      end
      ADD_SEL_ERR: begin
        add_a_s = thetan_nxt_q >>> POS_FRAC;
        add_b_s = theta_l_q;
      end
      default: begin
        add_a_s = 32'sd0;
        add_b_s = 32'sd0;
      end
    endcase
  end

  fixed_adder #(.N(32)) u_add (.a(add_a_s), .b(add_b_s), .op(add_op_s), .s(sum_s));

  // Magnitude of the error; the most negative value has no positive twin.
  always_comb begin
    if (sum_s == SAT32_MIN) begin
      abs_s = SAT32_MAX;
    end else if (sum_s[31]) begin
      abs_s = 32'sd0 - sum_s;
    end else begin
      abs_s = sum_s;
    end
  end

  assign u_wide_s     = {{32{u_l_q[31]}}, u_l_q};
  assign theta_wide_s = {{32{theta_l_q[31]}}, theta_l_q};

  // Datapath next-state: each step updates only its own scratch register;
  // published outputs change together in DONE.
  always_comb begin
    u_l_d         = u_l_q;
    theta_l_d     = theta_l_q;
    acc_d         = acc_q;
    prod_d        = prod_q;
    dthetan_nxt_d = dthetan_nxt_q;
    thetan_nxt_d  = thetan_nxt_q;
    err_d         = err_q;
    resync_flag_d = resync_flag_q;
    dthetan_d1_d  = dthetan_d1_q;
    thetan_d      = thetan_q;
    dthetan_d     = dthetan_q;
    dthetan_d2_d  = dthetan_d2_q;
    err_abs_d     = err_abs_q;
    resync_d      = 1'b0;
    if (latch_en_s) begin
      u_l_d     = u;
      theta_l_d = theta;
    end else begin
      u_l_d     = u_l_q;
      theta_l_d = theta_l_q;
    end
    case (state_s)
      ST_LOAD: acc_d = sat32(u_wide_s <<< ACC_SHIFT);
      ST_VMUL: begin
        // 32-bit velocity increment, re-saturated from the 48-bit multiplier.
        acc_d  = acc_q;
        prod_d = {{16{1'b0}}, 32'h0000_0000} |
                 48'(sat32({{16{mul_p_s[47]}}, mul_p_s}));
      end
      ST_VADD: dthetan_nxt_d = sum_s;
      ST_PMUL: prod_d = mul_p_s;
      ST_PADD: thetan_nxt_d = sum_s;
      ST_CAL: begin
        err_d         = abs_s;
        resync_flag_d = resync_en & ($unsigned(abs_s) > RESYNC_TH);
        if (resync_en && ($unsigned(abs_s) > RESYNC_TH)) begin
          thetan_nxt_d = sat32(theta_wide_s <<< POS_FRAC);
        end else begin
          thetan_nxt_d = thetan_nxt_q;
        end
      end
      ST_DONE: begin
        thetan_d     = thetan_nxt_q;
        dthetan_d    = dthetan_nxt_q;
        err_abs_d    = err_q;
        dthetan_d2_d = dthetan_d1_q;
        dthetan_d1_d = dthetan_q;
        resync_d     = resync_flag_q;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_l_q         <= 32'sd0;
      theta_l_q     <= 32'sd0;
      acc_q         <= 32'sd0;
      prod_q        <= 48'sd0;
      dthetan_nxt_q <= 32'sd0;
      thetan_nxt_q  <= 32'sd0;
      err_q         <= 32'sd0;
      resync_flag_q <= 1'b0;
      dthetan_d1_q  <= 32'sd0;
      thetan_q      <= 32'sd0;
      dthetan_q     <= 32'sd0;
      dthetan_d2_q  <= 32'sd0;
      err_abs_q     <= 32'sd0;
      resync_q      <= 1'b0;
    end else begin
      u_l_q         <= u_l_d;
      theta_l_q     <= theta_l_d;
      acc_q         <= acc_d;
      prod_q        <= prod_d;
      dthetan_nxt_q <= dthetan_nxt_d;
      thetan_nxt_q  <= thetan_nxt_d;
      err_q         <= err_d;
      resync_flag_q <= resync_flag_d;
      dthetan_d1_q  <= dthetan_d1_d;
      thetan_q      <= thetan_d;
      dthetan_q     <= dthetan_d;
      dthetan_d2_q  <= dthetan_d2_d;
      err_abs_q     <= err_abs_d;
      resync_q      <= resync_d;
    end
  end

  assign thetan     = thetan_q;
  assign dthetan    = dthetan_q;
  assign dthetan_d2 = dthetan_d2_q;
  assign err_abs    = err_abs_q;
  assign resync     = resync_q;

endmodule

// File: tb/tb_smc_nominal_sequencer.sv
// Self-checking bench for smc_nominal_sequencer (instantiated with RESYNC_TH=100).
module tb_smc_nominal_sequencer;

  localparam longint TS_M      = 2;
  localparam longint ACC_MUL   = 4;       // 2**ACC_SHIFT
  localparam int     POS_SHIFT = 16;
  localparam int     POS_FRAC  = 14;
  localparam longint FRAC_MUL  = 16384;   // 2**POS_FRAC
  localparam longint TH        = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        resync_en = 1'b0;
  logic [31:0] theta = 32'd0;
  logic [31:0] u = 32'd0;
  logic        busy, done, overrun, resync;
  logic [31:0] thetan, dthetan, dthetan_d2, err_abs;

  always #5 clk = ~clk;

  smc_nominal_sequencer #(.RESYNC_TH(32'd100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .resync_en  (resync_en),
    .theta      (theta),
    .u          (u),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .resync     (resync),
    .thetan     (thetan),
    .dthetan    (dthetan),
    .dthetan_d2 (dthetan_d2),
    .err_abs    (err_abs)
  );

  typedef struct {
    int thetan;
    int dthetan;
    int d2;
    int err;
    bit rs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   ovr_cnt = 0;
  int   m_thetan, m_dthetan, m_d1, m_d2;

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint s32(input longint v);
    return clamp(v, -64'sd2147483648, 64'sd2147483647);
  endfunction

  function automatic longint s48(input longint v);
    return clamp(v, -64'sd140737488355328, 64'sd140737488355327);
  endfunction

  // Reference model of one step; returns what the DUT must publish.
  function automatic exp_t model_step(input int uu, input int th, input bit en);
    exp_t   e;
    longint acc, prod, dn, p48, pinc, tn, diff, err;
    acc  = s32(longint'(uu) * ACC_MUL);
    prod = s32(acc * TS_M);
    dn   = s32(longint'(m_dthetan) + prod);
    p48  = s48(dn * TS_M);
    pinc = longint'(int'(p48 >>> POS_SHIFT));
    tn   = s32(longint'(m_thetan) + pinc);
    diff = s32((tn >>> POS_FRAC) - longint'(th));
    if (diff == -64'sd2147483648) err = 64'sd2147483647;
    else if (diff < 0) err = -diff;
    else err = diff;
    e.rs = en && (err > TH);
    if (e.rs) tn = s32(longint'(th) * FRAC_MUL);
    e.thetan  = int'(tn);
    e.dthetan = int'(dn);
    e.d2      = m_d1;
    e.err     = int'(err);
    m_d2      = m_d1;
    m_d1      = m_dthetan;
    m_dthetan = int'(dn);
    m_thetan  = int'(tn);
    return e;
  endfunction

  // Scoreboard: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got done=1 want no pending step");
      end else begin
        mon_e = sb.pop_front();
        if (thetan !== mon_e.thetan || dthetan !== mon_e.dthetan || dthetan_d2 !== mon_e.d2 ||
            err_abs !== mon_e.err || resync !== mon_e.rs) begin
          errors++;
          $display("FAIL step_results got th=%0d dth=%0d d2=%0d err=%0d rs=%0b want th=%0d dth=%0d d2=%0d err=%0d rs=%0b",
                   $signed(thetan), $signed(dthetan), $signed(dthetan_d2), err_abs, resync,
                   mon_e.thetan, mon_e.dthetan, mon_e.d2, mon_e.err, mon_e.rs);
        end
      end
    end
    if (rst_n && resync) begin
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL resync_without_done got done=%0b want 1", done);
      end
    end
    if (rst_n && overrun) ovr_cnt++;
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    resync_en = 1'b0;
    sb.delete();
    m_thetan = 0; m_dthetan = 0; m_d1 = 0; m_d2 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drive one accepted start; returns one negedge after the strobe.
  task automatic do_start(input int uu, input int th, input bit en);
    @(negedge clk);
    u = uu; theta = th; resync_en = en; start = 1'b1;
    sb.push_back(model_step(uu, th, en));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, overrun, resync, thetan, dthetan, dthetan_d2, err_abs} !== 132'd0) begin
      errors++;
      $display("FAIL reset_outputs got th=%0d dth=%0d busy=%0b want all 0", thetan, dthetan, busy);
    end
    apply_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
  endtask

  task automatic test_single_step();
    int lat = -1;
    int busy_cnt = 0;
    apply_reset();
    do_start(414, 0, 1'b0);
    if (busy === 1'b1) busy_cnt++;
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && lat < 0) lat = i;
    end
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL single_latency got %0d want 8", lat); end
    checks++;
    if (busy_cnt !== 8) begin errors++; $display("FAIL single_busy_cycles got %0d want 8", busy_cnt); end
    checks++;
    if (dthetan !== 32'd3312 || thetan !== 32'd0 || err_abs !== 32'd0) begin
      errors++;
      $display("FAIL single_values got dth=%0d th=%0d err=%0d want 3312 0 0", dthetan, thetan, err_abs);
    end
  endtask

  task automatic test_back_to_back();
    int d0, o0;
    apply_reset();
    d0 = done_cnt; o0 = ovr_cnt;
    for (int s = 0; s < 10; s++) begin
      do_start(414, 0, 1'b0);
      repeat (7) @(negedge clk);
    end
    checks++;
    if (dthetan !== 32'd33120 || dthetan_d2 !== 32'd26496) begin
      errors++;
      $display("FAIL ten_velocity got dth=%0d d2=%0d want 33120 26496", dthetan, dthetan_d2);
    end
    // Step 10 is the first with a non-zero increment: 66240>>>16 = 1.
    checks++;
    if (thetan !== 32'd1) begin errors++; $display("FAIL ten_position got %0d want 1", thetan); end
    for (int s = 10; s < 4000; s++) begin
      do_start(414, int'($urandom_range(0, 4000)) - 2000, 1'b0);
      repeat (7) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (dthetan !== 32'd13248000) begin errors++; $display("FAIL long_velocity got %0d want 13248000", dthetan); end
    checks++;
    if (done_cnt - d0 !== 4000 || sb.size() !== 0) begin
      errors++;
      $display("FAIL long_done_count got %0d pending=%0d want 4000 0", done_cnt - d0, sb.size());
    end
    checks++;
    if (ovr_cnt !== o0) begin errors++; $display("FAIL long_no_overrun got %0d want 0", ovr_cnt - o0); end
  endtask

  task automatic test_saturation();
    apply_reset();
    do_start(32'h7FFF_FFFF, 0, 1'b0);
    repeat (7) @(negedge clk);
    checks++;
    if (dthetan !== 32'h7FFF_FFFF || thetan !== 32'd65535) begin
      errors++;
      $display("FAIL sat_first got dth=%h th=%0d want 7fffffff 65535", dthetan, thetan);
    end
    do_start(32'h7FFF_FFFF, 0, 1'b0);
    repeat (7) @(negedge clk);
    checks++;
    if (dthetan !== 32'h7FFF_FFFF || thetan !== 32'd131070) begin
      errors++;
      $display("FAIL sat_second got dth=%h th=%0d want 7fffffff 131070", dthetan, thetan);
    end
  endtask

  task automatic test_resync();
    apply_reset();
    do_start(0, 1000, 1'b1);
    repeat (7) @(negedge clk);
    checks++;
    if (resync !== 1'b1 || done !== 1'b1 || thetan !== 32'd16384000 || err_abs !== 32'd1000) begin
      errors++;
      $display("FAIL resync_reload got rs=%0b done=%0b th=%0d err=%0d want 1 1 16384000 1000",
               resync, done, thetan, err_abs);
    end
    apply_reset();
    do_start(0, 50, 1'b1);
    repeat (7) @(negedge clk);
    checks++;
    if (resync !== 1'b0 || thetan !== 32'd0 || err_abs !== 32'd50) begin
      errors++;
      $display("FAIL resync_below_th got rs=%0b th=%0d err=%0d want 0 0 50", resync, thetan, err_abs);
    end
    resync_en = 1'b0;
  endtask

  task automatic test_overrun();
    int d0, o0;
    apply_reset();
    d0 = done_cnt; o0 = ovr_cnt;
    do_start(414, 0, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got %0b want 1", overrun); end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || ovr_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL overrun_counts got done=%0d ovr=%0d want 1 1", done_cnt - d0, ovr_cnt - o0);
    end
    checks++;
    if (dthetan !== 32'd3312 || thetan !== 32'd0) begin
      errors++;
      $display("FAIL overrun_values got dth=%0d th=%0d want 3312 0", dthetan, thetan);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    apply_reset();
    do_start(414, 0, 1'b0);
    repeat (7) @(negedge clk);
    do_start(414, 0, 1'b0);
    repeat (3) @(negedge clk);   // DUT now in PMUL
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overrun, resync, thetan, dthetan, dthetan_d2, err_abs} !== 132'd0) begin
      errors++;
      $display("FAIL abort_outputs got dth=%0d th=%0d busy=%0b want all 0", dthetan, thetan, busy);
    end
    apply_reset();
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt - d0); end
    do_start(414, 0, 1'b0);
    repeat (7) @(negedge clk);
    checks++;
    if (dthetan !== 32'd3312 || thetan !== 32'd0 || err_abs !== 32'd0 || dthetan_d2 !== 32'd0) begin
      errors++;
      $display("FAIL abort_restart got dth=%0d th=%0d err=%0d d2=%0d want 3312 0 0 0",
               dthetan, thetan, err_abs, dthetan_d2);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_step();
    test_back_to_back();
    test_saturation();
    test_resync();
    test_overrun();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
